// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared constants and helpers for the fetch-side PC sequencer.
// Holds the FSM state encodings, the reset PC, the sequential step and
// the word-alignment helper used when loading redirect targets.
package fetch_pc_sequencer_pkg;

    // FSM state encodings (kept as plain constants for legacy compatibility)
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    // Default PC after reset (MIPS boot ROM vector)
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Sequential increment in bytes between consecutive instructions
    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction addresses are always word aligned; low two bits are dropped
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Bundle of the fetch sequencer's pipeline-control, instruction-memory and
// IF/ID signals. The master modport is the sequencer's view; the slave
// modport is the view of whatever surrounds it (decode, memory, IF/ID).
interface fetch_pc_sequencer_if;

    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectAddr;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;

    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPcPlus4;
    logic [31:0] fetchPc;

    modport master (
        input  stall,
        input  redirectValid,
        input  redirectAddr,
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData,
        output instrValid,
        output instruction,
        output instrPcPlus4,
        output fetchPc
    );

    modport slave (
        output stall,
        output redirectValid,
        output redirectAddr,
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData,
        input  instrValid,
        input  instruction,
        input  instrPcPlus4,
        input  fetchPc
    );

endinterface

// File: rtl/fetch_pc_sequencer_skid.sv
// Single-entry skid buffer for the fetch sequencer. Parks a word (and its
// PC+4) that completed while the pipeline was frozen, until the freeze lifts.
module fetch_skid_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] dataIn,
    input  logic [31:0] pcPlus4In,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pcPlus4
);

    // Capture a frozen word on load, drop it once it has been presented
    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= 1'b0;
            data    <= 32'd0;
            pcPlus4 <= 32'd0;
        end else if (load) begin
            valid   <= 1'b1;
            data    <= dataIn;
            pcPlus4 <= pcPlus4In;
        end else if (clear) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the architectural PC, issues instruction-memory
// reads, hands each fetched word plus its PC+4 to IF/ID, applies decode
// redirects after the branch delay slot and freezes on the pipeline stall.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_pc_sequencer_if.master  bus
);

    logic [0:0]  state;
    logic [31:0] pc;
    logic        pendingValid;
    logic [31:0] pendingAddr;

    logic        instrValidReg;
    logic [31:0] instructionReg;
    logic [31:0] instrPcPlus4Reg;

    logic        bufValid;
    logic [31:0] bufData;
    logic [31:0] bufPcPlus4;

    logic        fetchDone;
    logic        captureWord;
    logic        deliverDirect;
    logic        releaseHold;
    logic        advance;
    logic        takeRedirect;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;

    // Classify this cycle: a word completing, being parked, or being released
    always_comb begin
        fetchDone     = (state == FETCH) && bus.imemReady;
        captureWord   = fetchDone && bus.stall;
        deliverDirect = fetchDone && !bus.stall;
        releaseHold   = (state == HOLD) && bufValid && !bus.stall;
        advance       = deliverDirect || releaseHold;
        takeRedirect  = bus.redirectValid && !bus.stall && !pendingValid;
        pcPlus4       = pc + PC_STEP;
    end

    // Pick the next PC: same-cycle redirect, then a pending target, then PC+4
    always_comb begin
        nextPc = pcPlus4;
        if (takeRedirect) begin
            nextPc = alignWord(bus.redirectAddr);
        end else if (pendingValid) begin
            nextPc = pendingAddr;
        end
    end

    // PC register and the redirect that waits for its delay slot to complete
    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            pendingValid <= 1'b0;
            pendingAddr  <= 32'd0;
        end else if (advance) begin
            pc           <= nextPc;
            pendingValid <= 1'b0;
        end else if (takeRedirect) begin
            pendingValid <= 1'b1;
            pendingAddr  <= alignWord(bus.redirectAddr);
        end
    end

    // FSM: park in HOLD when a word lands during a freeze, leave when released
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (captureWord) state <= HOLD;
                HOLD:    if (releaseHold) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // IF/ID presentation: one-cycle valid pulse, payload holds between pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            instrValidReg   <= 1'b0;
            instructionReg  <= 32'd0;
            instrPcPlus4Reg <= 32'd0;
        end else begin
            instrValidReg <= 1'b0;
            if (deliverDirect) begin
                instrValidReg   <= 1'b1;
                instructionReg  <= bus.imemData;
                instrPcPlus4Reg <= pcPlus4;
            end else if (releaseHold) begin
                instrValidReg   <= 1'b1;
                instructionReg  <= bufData;
                instrPcPlus4Reg <= bufPcPlus4;
            end
        end
    end

    fetch_skid_buffer skid (
        .clock     (clock),
        .reset     (reset),
        .load      (captureWord),
        .clear     (releaseHold),
        .dataIn    (bus.imemData),
        .pcPlus4In (pcPlus4),
        .valid     (bufValid),
        .data      (bufData),
        .pcPlus4   (bufPcPlus4)
    );

    assign bus.imemReq      = (state == FETCH);
    assign bus.imemAddr     = pc;
    assign bus.fetchPc      = pc;
    assign bus.instrValid   = instrValidReg;
    assign bus.instruction  = instructionReg;
    assign bus.instrPcPlus4 = instrPcPlus4Reg;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed testbench for the fetch PC sequencer. Each completed fetch pushes
// its expected word and PC+4 to a scoreboard that is drained whenever the
// sequencer pulses its valid output.
module tb_fetch_pc_sequencer;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] sbq[$];

    fetch_pc_sequencer_if bus ();

    fetch_pc_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    always #5 clock = ~clock;

    // Instruction memory contents as seen by the bench
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the next rising edge, then idle them
    task automatic applyStimulus(input logic rst, input logic rdy, input logic [31:0] data,
                                 input logic stl, input logic rv, input logic [31:0] ra);
        reset             = rst;
        bus.imemReady     = rdy;
        bus.imemData      = data;
        bus.stall         = stl;
        bus.redirectValid = rv;
        bus.redirectAddr  = ra;
        @(posedge clock);
        #1;
        reset             = 1'b0;
        bus.imemReady     = 1'b0;
        bus.imemData      = 32'd0;
        bus.stall         = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectAddr  = 32'd0;
    endtask

    // Complete the outstanding fetch at expAddr and expect it to be delivered
    task automatic completeFetch(input string tag, input logic [31:0] expAddr, input logic [31:0] data,
                                 input logic stl, input logic rv, input logic [31:0] ra);
        checkOutput({tag, ".req"}, {31'd0, bus.imemReq}, 32'd1);
        checkOutput({tag, ".addr"}, bus.imemAddr, expAddr);
        sbq.push_back({data, expAddr + 32'd4});
        applyStimulus(1'b0, 1'b1, data, stl, rv, ra);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic checkDrained(input string tag);
        idleCycle();
        checkOutput({tag, ".drained"}, sbq.size(), 32'd0);
    endtask

    // Scoreboard: every valid pulse must match the oldest expected delivery
    always @(negedge clock) begin
        logic [63:0] exp;
        if (bus.instrValid === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput("spuriousValid", {31'd0, bus.instrValid}, 32'd0);
            end else begin
                exp = sbq.pop_front();
                checkOutput("sb.instruction", bus.instruction, exp[63:32]);
                checkOutput("sb.pcPlus4", bus.instrPcPlus4, exp[31:0]);
            end
        end
    end

    // Directed sequence
    initial begin
        reset             = 1'b1;
        bus.imemReady     = 1'b0;
        bus.imemData      = 32'd0;
        bus.stall         = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectAddr  = 32'd0;

        // Reset state
        doReset();
        checkOutput("rst.valid", {31'd0, bus.instrValid}, 32'd0);
        checkOutput("rst.instruction", bus.instruction, 32'd0);
        checkOutput("rst.pcPlus4", bus.instrPcPlus4, 32'd0);
        checkOutput("rst.fetchPc", bus.fetchPc, 32'hBFC0_0000);

        // Back-to-back sequential fetch
        completeFetch("seq0", 32'hBFC0_0000, memWord(32'hBFC0_0000), 1'b0, 1'b0, 32'd0);
        completeFetch("seq1", 32'hBFC0_0004, memWord(32'hBFC0_0004), 1'b0, 1'b0, 32'd0);
        checkOutput("seq1.valid", {31'd0, bus.instrValid}, 32'd1);
        completeFetch("seq2", 32'hBFC0_0008, memWord(32'hBFC0_0008), 1'b0, 1'b0, 32'd0);
        checkOutput("seq2.valid", {31'd0, bus.instrValid}, 32'd1);
        checkOutput("seq.fetchPc", bus.fetchPc, 32'hBFC0_000C);
        checkDrained("seq");

        // Redirect while the delay-slot fetch is still outstanding
        doReset();
        completeFetch("dly0", 32'hBFC0_0000, memWord(32'hBFC0_0000), 1'b0, 1'b0, 32'd0);
        completeFetch("dly1", 32'hBFC0_0004, memWord(32'hBFC0_0004), 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0040_0020);
        checkOutput("dly.holdAddr", bus.imemAddr, 32'hBFC0_0008);
        idleCycle();
        completeFetch("dly.slot", 32'hBFC0_0008, memWord(32'hBFC0_0008), 1'b0, 1'b0, 32'd0);
        completeFetch("dly.target", 32'h0040_0020, memWord(32'h0040_0020), 1'b0, 1'b0, 32'd0);
        checkDrained("dly");

        // Redirect in the same cycle a fetch completes
        doReset();
        completeFetch("same0", 32'hBFC0_0000, memWord(32'hBFC0_0000), 1'b0, 1'b0, 32'd0);
        completeFetch("same1", 32'hBFC0_0004, memWord(32'hBFC0_0004), 1'b0, 1'b1, 32'h0040_0100);
        completeFetch("same.target", 32'h0040_0100, memWord(32'h0040_0100), 1'b0, 1'b0, 32'd0);
        checkDrained("same");

        // Word lands during a three-cycle freeze; a redirect under stall is ignored
        doReset();
        completeFetch("stl0", 32'hBFC0_0000, memWord(32'hBFC0_0000), 1'b0, 1'b0, 32'd0);
        completeFetch("stl1", 32'hBFC0_0004, 32'h8C02_0004, 1'b1, 1'b0, 32'd0);
        checkOutput("stl.c1.req", {31'd0, bus.imemReq}, 32'd0);
        checkOutput("stl.c1.pc", bus.fetchPc, 32'hBFC0_0004);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1234_5678);
        checkOutput("stl.c2.valid", {31'd0, bus.instrValid}, 32'd0);
        checkOutput("stl.c2.pc", bus.fetchPc, 32'hBFC0_0004);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("stl.c3.valid", {31'd0, bus.instrValid}, 32'd0);
        checkOutput("stl.c3.req", {31'd0, bus.imemReq}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("stl.release.valid", {31'd0, bus.instrValid}, 32'd1);
        completeFetch("stl.resume", 32'hBFC0_0008, memWord(32'hBFC0_0008), 1'b0, 1'b0, 32'd0);
        checkDrained("stl");

        // Unaligned redirect to the top of memory, wrap, and ignored second redirect
        doReset();
        completeFetch("wrap0", 32'hBFC0_0000, memWord(32'hBFC0_0000), 1'b0, 1'b1, 32'hFFFF_FFFF);
        completeFetch("wrap.top", 32'hFFFF_FFFC, memWord(32'hFFFF_FFFC), 1'b0, 1'b0, 32'd0);
        checkOutput("wrap.addr", bus.imemAddr, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0200);
        completeFetch("wrap.slot", 32'h0000_0000, memWord(32'h0000_0000), 1'b0, 1'b0, 32'd0);
        completeFetch("wrap.first", 32'h0000_0100, memWord(32'h0000_0100), 1'b0, 1'b0, 32'd0);
        checkOutput("wrap.seqAddr", bus.imemAddr, 32'h0000_0104);

        // Reset while a request is outstanding with a pending redirect
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0300);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        checkOutput("mid.addr", bus.imemAddr, 32'hBFC0_0000);
        checkOutput("mid.valid", {31'd0, bus.instrValid}, 32'd0);
        checkOutput("mid.instruction", bus.instruction, 32'd0);
        idleCycle();
        checkOutput("mid.idleValid", {31'd0, bus.instrValid}, 32'd0);
        completeFetch("mid.boot", 32'hBFC0_0000, memWord(32'hBFC0_0000), 1'b0, 1'b0, 32'd0);
        checkOutput("mid.noPending", bus.imemAddr, 32'hBFC0_0004);
        checkDrained("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Fetch-side consumer of the next-instruction address computed in decode. Owns the architectural PC and issues instruction-memory reads with a req/ready handshake. Delivers each fetched word plus its PC+4 to the IF/ID register. Applies decode redirects (taken branch, j/jal, jr/jalr) after the branch delay slot, and freezes on the forwarding-logic stall.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
CLOCK  in  1  sole clock, rising edge
RESET  in  1  synchronous, active-high
STALL  in  1  pipeline freeze (FWD_REQ_FREEZE); IF/ID must not advance
Redirect_Valid  in  1  decode has a taken branch/jump this cycle
Redirect_Addr  in  32  target address from the next-instruction calculator
IMem_Req  out  1  read request to instruction memory
IMem_Addr  out  32  word address of the request
IMem_Ready  in  1  IMem_Data valid this cycle; completes the request
IMem_Data  in  32  fetched instruction word
Instr_Valid  out  1  one-cycle pulse: new Instruction/Instr_PC_Plus4 presented
Instruction  out  32  fetched word to IF/ID
Instr_PC_Plus4  out  32  PC of presented instruction + PC_STEP
Fetch_PC  out  32  current PC (debug)

Behaviour:
- Reset (RESET high at an edge): PC=RESET_PC, state=FETCH, pending_valid=0, pending_addr=0, Instr_Valid=0, Instruction=0, Instr_PC_Plus4=0, buffer cleared. RESET mid-request abandons it; any IMem_Ready arriving in the reset cycle is ignored.
- States:
  - FETCH: IMem_Req=1, IMem_Addr=PC. Once raised, req and address stay stable until IMem_Ready.
  - HOLD: IMem_Req=0. A completed word is buffered while STALL is high.
- FETCH with IMem_Ready=1 and STALL=0:
  - Next edge: Instruction=IMem_Data, Instr_PC_Plus4=PC+4, Instr_Valid=1.
  - PC <= next_pc. Stay in FETCH.
  - Latency from IMem_Ready to Instr_Valid: 1 cycle.
- FETCH with IMem_Ready=1 and STALL=1:
  - Capture data and PC+4 into the skid buffer; go to HOLD.
  - PC does not advance yet. Instr_Valid=0.
- HOLD with STALL=0:
  - Next edge: present the buffered word with Instr_Valid=1.
  - PC <= next_pc. Return to FETCH.
- HOLD with STALL=1: remain in HOLD. All outputs are held and Instr_Valid=0.
- next_pc selection, in priority order:
  1. Redirect_Valid && !STALL in the same cycle: Redirect_Addr. The completing word is the delay slot of the branch in decode.
  2. pending_valid: pending_addr. Clear pending_valid.
  3. Otherwise: PC+4. 32-bit wrap; 32'hFFFFFFFC+4 = 0.
- Redirect_Valid && !STALL with no fetch completing that cycle:
  - Latch pending_addr=Redirect_Addr, pending_valid=1.
  - The outstanding or next completing fetch is the delay slot and is still delivered. pending is applied after it.
- Redirect_Valid while STALL=1: ignored. Decode re-asserts it after the freeze.
- Redirect_Valid while pending_valid=1 (branch in a delay slot, architecturally undefined): ignored; the first target wins.
- Instr_Valid is low in every cycle without a new presentation. Instruction and Instr_PC_Plus4 hold their last values.
- Fetch_PC always equals the PC register.
- Address width: PC[1:0] is always 00. A Redirect_Addr with nonzero [1:0] is forced to 00 on load.

Decomposition:
- Shared package/config include holds:
  - State encodings FETCH=1'b0, HOLD=1'b1.
  - RESET_PC default and the PC_STEP constant.
- The skid buffer (valid, data, pc_plus4) is natural as one sub-module: fetch_skid_buffer.
- PC and redirect logic stay in the top.

Test Plan:
- Reset, then IMem_Ready=1 every cycle with no stall:
  - IMem_Addr sequence is BFC00000, BFC00004, BFC00008.
  - Instr_PC_Plus4 sequence is BFC00004, BFC00008, …
  - Instr_Valid stays high from the second cycle on.
- Redirect_Valid=1 with Redirect_Addr=00400020 while the fetch at BFC00008 has IMem_Ready=0 (arrives 2 cycles later):
  - Word at BFC00008 is delivered as the delay slot.
  - The next IMem_Addr is 00400020.
- Redirect_Valid in the same cycle as the fetch of BFC00004 completes (target 00400100): next IMem_Addr=00400100.
- STALL=1 for 3 cycles while IMem_Ready arrives with data 8C020004:
  - State is HOLD. No Instr_Valid pulse, and PC stays put.
  - On STALL release, Instr_Valid pulses with Instruction=8C020004, then fetch resumes at PC+4.
- Redirect to FFFFFFFC, then sequential fetch: next address is 00000000. A second redirect during pending is ignored.
- Assert RESET while IMem_Req is outstanding with pending_valid=1:
  - Next cycle IMem_Addr=BFC00000, pending cleared, Instr_Valid=0.
  - A late IMem_Ready in the reset cycle produces no output.
